// File: rtl/fma_pkg.sv
// Shared types and constants for FMA datapath blocks and the shared multiplier.
// The 27x27 product is built from a 14-bit low and a 13-bit high slice of b.
package fma_pkg;

  localparam int MUL_W   = 27;
  localparam int PROD_W  = 54;
  localparam int MUL_LAT = 3;
  localparam int SPLIT_W = 14;
  localparam int LO_W    = MUL_W + SPLIT_W;
  localparam int HI_W    = MUL_W + (MUL_W - SPLIT_W);

  typedef logic [MUL_W-1:0]  opnd_t;
  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    opnd_t a;
    opnd_t b;
  } mul_req_t;

  typedef struct packed {
    prod_t p;
  } mul_rsp_t;

  typedef struct packed {
    logic [LO_W-1:0] lo;
    logic [HI_W-1:0] hi;
  } part_prod_t;

  // The sum always fits in PROD_W because a*b < 2^54.
  function automatic prod_t combine_pp(input part_prod_t pp);
    return PROD_W'(pp.lo) + (PROD_W'(pp.hi) << SPLIT_W);
  endfunction

endpackage

// File: rtl/mul_pipe.sv
// Three-stage split 27x27 multiplier carrying a {valid, index, tag} sideband.
// Never stalls; one result per cycle, MUL_LAT cycles after the operands enter.
module mul_pipe
  import fma_pkg::*;
#(
  parameter int TAGW = 4,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  input  logic [IDXW-1:0]   in_idx_i,
  input  logic [TAGW-1:0]   in_tag_i,
  input  logic [MUL_W-1:0]  in_a_i,
  input  logic [MUL_W-1:0]  in_b_i,
  output logic              out_valid_o,
  output logic [IDXW-1:0]   out_idx_o,
  output logic [TAGW-1:0]   out_tag_o,
  output logic [PROD_W-1:0] out_p_o,
  output logic              busy_o
);

  logic            s1_vld_q, s2_vld_q, s3_vld_q;
  logic [IDXW-1:0] s1_idx_q, s2_idx_q, s3_idx_q;
  logic [TAGW-1:0] s1_tag_q, s2_tag_q, s3_tag_q;
  mul_req_t        s1_opnd_q;
  part_prod_t      s2_pp_q, s2_pp_d;
  prod_t           s3_p_q, s3_p_d;

  always_comb begin
    s2_pp_d.lo = LO_W'(s1_opnd_q.a) * LO_W'(s1_opnd_q.b[SPLIT_W-1:0]);
    s2_pp_d.hi = HI_W'(s1_opnd_q.a) * HI_W'(s1_opnd_q.b[MUL_W-1:SPLIT_W]);
    s3_p_d     = combine_pp(s2_pp_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= in_valid_i;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
    end
  end

  // NOTE: stage 1/2 payloads are only consumed behind their valid bit, so they
  // carry no reset; only the visible output stage is cleared.
  always_ff @(posedge clk) begin
    if (in_valid_i) begin
      s1_opnd_q <= '{a: in_a_i, b: in_b_i};
      s1_idx_q  <= in_idx_i;
      s1_tag_q  <= in_tag_i;
    end
    if (s1_vld_q) begin
      s2_pp_q  <= s2_pp_d;
      s2_idx_q <= s1_idx_q;
      s2_tag_q <= s1_tag_q;
    end
  end

  // Output stage holds its last value while no valid entry arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_p_q   <= '0;
      s3_idx_q <= '0;
      s3_tag_q <= '0;
    end else if (s2_vld_q) begin
      s3_p_q   <= s3_p_d;
      s3_idx_q <= s2_idx_q;
      s3_tag_q <= s2_tag_q;
    end
  end

  assign out_valid_o = s3_vld_q;
  assign out_idx_o   = s3_idx_q;
  assign out_tag_o   = s3_tag_q;
  assign out_p_o     = s3_p_q;
  assign busy_o      = s1_vld_q | s2_vld_q | s3_vld_q;

endmodule

// File: rtl/mul_server.sv
// Round-robin arbiter in front of a shared pipelined 27x27 multiplier; the
// product returns to the granted client with its tag after MUL_LAT cycles.
module mul_server
  import fma_pkg::*;
#(
  parameter int NCLIENT = 4,
  parameter int TAGW    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NCLIENT-1:0]              req_valid,
  output logic [NCLIENT-1:0]              req_ready,
  input  logic [NCLIENT-1:0][MUL_W-1:0]   req_a,
  input  logic [NCLIENT-1:0][MUL_W-1:0]   req_b,
  input  logic [NCLIENT-1:0][TAGW-1:0]    req_tag,
  output logic [NCLIENT-1:0]              rsp_valid,
  output logic [PROD_W-1:0]               rsp_data,
  output logic [TAGW-1:0]                 rsp_tag,
  output logic                            busy
);

  localparam int IDXW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;
  localparam int CW   = IDXW + 1;

  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] grant_idx;
  logic            fire;
  logic [CW-1:0]   cand;

  logic            out_vld;
  logic [IDXW-1:0] out_idx;

  // NOTE: blocking assignments here; the loop reads fire/cand from earlier
  // iterations of the same pass, and every output gets a default first so no
  // latch is inferred.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    fire      = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NCLIENT; k++) begin
      cand = {1'b0, last_q} + CW'(k);
      if (cand >= CW'(NCLIENT)) cand = cand - CW'(NCLIENT);
      if (!fire && req_valid[cand[IDXW-1:0]]) begin
        fire      = 1'b1;
        grant_idx = cand[IDXW-1:0];
      end
    end
    if (reset) fire = 1'b0;
    if (fire) req_ready[grant_idx] = 1'b1;
    last_d = fire ? grant_idx : last_q;
  end

  // Pointer starts at the last client so client 0 wins the first search.
  always_ff @(posedge clk) begin
    if (reset) last_q <= IDXW'(NCLIENT - 1);
    else       last_q <= last_d;
  end

  mul_pipe #(
    .TAGW (TAGW),
    .IDXW (IDXW)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (fire),
    .in_idx_i    (grant_idx),
    .in_tag_i    (req_tag[grant_idx]),
    .in_a_i      (req_a[grant_idx]),
    .in_b_i      (req_b[grant_idx]),
    .out_valid_o (out_vld),
    .out_idx_o   (out_idx),
    .out_tag_o   (rsp_tag),
    .out_p_o     (rsp_data),
    .busy_o      (busy)
  );

  always_comb begin
    rsp_valid = '0;
    if (out_vld) rsp_valid[out_idx] = 1'b1;
  end

endmodule

// File: tb/tb_mul_server.sv
// Directed bench for mul_server: arbitration order, split-boundary products,
// random operands on one client, reset with products in flight, withdrawal.
module tb_mul_server;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          req_valid;
  logic [3:0]          req_ready;
  logic [3:0][26:0]    req_a;
  logic [3:0][26:0]    req_b;
  logic [3:0][3:0]     req_tag;
  logic [3:0]          rsp_valid;
  logic [53:0]         rsp_data;
  logic [3:0]          rsp_tag;
  logic                busy;

  mul_server #(.NCLIENT(4), .TAGW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          client;
    logic [3:0]  tag;
    logic [53:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Response monitor: the head entry is due in exactly one cycle; any other
  // cycle must show no response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t       e;
        logic [3:0] oh;
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.client;
        check("rsp_valid", 64'(rsp_valid), 64'(oh));
        check("rsp_data", 64'(rsp_data), 64'(e.p));
        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
      end else begin
        check("rsp_idle", 64'(rsp_valid), 64'd0);
      end
    end
  end

  // Drive req_valid for one cycle, check the grant, record the expected
  // response, then advance to just after the next rising edge.
  task automatic step(input logic [3:0] v, input logic [3:0] exp_rdy,
                      input bit use_hand, input logic [53:0] hand_p);
    req_valid = v;
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < 4; i++) begin
      if (exp_rdy[i]) begin
        exp_t e;
        e.due    = cyc + 3;
        e.client = i;
        e.tag    = req_tag[i];
        e.p      = use_hand ? hand_p : 54'(req_a[i]) * 54'(req_b[i]);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 4'b0000, 1'b0, '0);
  endtask

  // One-cycle reset; products that would surface after the reset edge are dropped.
  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 4'b0000;
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc)
      exp_q.delete(exp_q.size() - 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [26:0] bnd_a [6];
  logic [26:0] bnd_b [6];
  logic [53:0] bnd_p [6];

  initial begin
    bnd_a[0] = 27'h4000;    bnd_b[0] = 27'h4000;    bnd_p[0] = 54'h10000000;
    bnd_a[1] = 27'h1;       bnd_b[1] = 27'h3FFF;    bnd_p[1] = 54'h3FFF;
    bnd_a[2] = 27'h7FFFFFF; bnd_b[2] = 27'h4000;    bnd_p[2] = 54'h1FFFFFFC000;
    bnd_a[3] = 27'h7FFFFFF; bnd_b[3] = 27'h3FFF;    bnd_p[3] = 54'h1FFF7FFC001;
    bnd_a[4] = 27'h0;       bnd_b[4] = 27'h7FFFFFF; bnd_p[4] = 54'h0;
    bnd_a[5] = 27'h3;       bnd_b[5] = 27'h5;       bnd_p[5] = 54'hF;

    reset     = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    reset     = 1'b0;
    req_valid = 4'b0000;
    mon_en    = 1'b1;

    // Largest operands on client 0; busy spans exactly three cycles.
    req_a[0] = 27'h7FFFFFF; req_b[0] = 27'h7FFFFFF; req_tag[0] = 4'd5;
    step(4'b0001, 4'b0001, 1'b1, 54'h3FFFFFF0000001);
    check("busy_s1", 64'(busy), 64'd1);
    idle(1);
    check("busy_s2", 64'(busy), 64'd1);
    idle(1);
    check("busy_s3", 64'(busy), 64'd1);
    idle(1);
    check("busy_done", 64'(busy), 64'd0);

    // All four clients continuously after reset: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 27'(i + 1); req_b[i] = 27'd3; req_tag[i] = 4'(8 + i);
    end
    step(4'b1111, 4'b0001, 1'b1, 54'd3);
    step(4'b1111, 4'b0010, 1'b1, 54'd6);
    step(4'b1111, 4'b0100, 1'b1, 54'd9);
    step(4'b1111, 4'b1000, 1'b1, 54'd12);
    step(4'b1111, 4'b0001, 1'b1, 54'd3);
    idle(4);

    // Wrap order with clients 1 and 3, client 2 joining mid-stream.
    req_a[1] = 27'd100;    req_b[1] = 27'd7;    req_tag[1] = 4'd1;
    req_a[2] = 27'h123;    req_b[2] = 27'h10;   req_tag[2] = 4'd2;
    req_a[3] = 27'h5555;   req_b[3] = 27'd2;    req_tag[3] = 4'd3;
    step(4'b0010, 4'b0010, 1'b1, 54'd700);
    step(4'b1010, 4'b1000, 1'b1, 54'hAAAA);
    step(4'b1010, 4'b0010, 1'b1, 54'd700);
    step(4'b1110, 4'b0100, 1'b1, 54'h1230);
    step(4'b1110, 4'b1000, 1'b1, 54'hAAAA);
    step(4'b1110, 4'b0010, 1'b1, 54'd700);
    idle(4);

    // Split-boundary operands back to back on client 0.
    for (int i = 0; i < 6; i++) begin
      req_a[0] = bnd_a[i]; req_b[0] = bnd_b[i]; req_tag[0] = 4'(i);
      step(4'b0001, 4'b0001, 1'b1, bnd_p[i]);
    end

    // Random operands, one grant per cycle, checked against a*b.
    for (int i = 0; i < 10000; i++) begin
      req_a[0]   = 27'($urandom);
      req_b[0]   = 27'($urandom);
      req_tag[0] = 4'($urandom);
      step(4'b0001, 4'b0001, 1'b0, '0);
    end

    // Reset with three products in flight.
    for (int i = 0; i < 3; i++) begin
      req_a[0] = 27'(1000 + i); req_b[0] = 27'd9; req_tag[0] = 4'(i + 4);
      step(4'b0001, 4'b0001, 1'b0, '0);
    end
    reset     = 1'b1;
    req_valid = 4'b0001;
    #1;
    check("ready_in_reset", 64'(req_ready), 64'd0);
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].due > cyc)
      exp_q.delete(exp_q.size() - 1);
    @(posedge clk);
    #1;
    check("busy_after_rst", 64'(busy), 64'd0);
    check("rsp_after_rst", 64'(rsp_valid), 64'd0);
    reset = 1'b0;
    req_a[2] = 27'd11; req_b[2] = 27'd13; req_tag[2] = 4'd7;
    req_a[3] = 27'd17; req_b[3] = 27'd19; req_tag[3] = 4'd9;
    step(4'b1100, 4'b0100, 1'b1, 54'd143);

    // Client 0 withdraws before being granted; clients 3 then 1 proceed.
    req_a[0] = 27'd5;  req_b[0] = 27'd5;  req_tag[0] = 4'hC;
    req_a[1] = 27'd21; req_b[1] = 27'd2;  req_tag[1] = 4'h6;
    req_a[3] = 27'd9;  req_b[3] = 27'd9;  req_tag[3] = 4'hA;
    step(4'b1001, 4'b1000, 1'b1, 54'd81);
    step(4'b0010, 4'b0010, 1'b1, 54'd42);
    idle(5);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule
